// File: rtl/shared_adder_arbiter_if.sv
// Requester-side bus of the shared adder: packed request/operand vectors in,
// one-hot grant and registered sum/status back.
interface shared_adder_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      result;
  logic                  ovf;
  logic                  done;
  logic                  busy;

  modport master (
    output req, op_a, op_b,
    input  gnt, result, ovf, done, busy
  );

  modport slave (
    input  req, op_a, op_b,
    output gnt, result, ovf, done, busy
  );
endinterface

// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter sharing one adder; gnt 1 edge and done 2 edges after req is sampled, one op per 3 cycles,
// no backpressure (done is a pulse). Define OVERFLOW_SAT_EN to saturate the result on carry instead of wrapping.
module shared_adder_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input logic                 clk,
  input logic                 rst,
  shared_adder_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    ptr_nxt;
  logic [WIDTH:0]   sum;

  // Walk downward from the farthest candidate so the nearest set bit above ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req[(int'(ptr) + k) % NREQ]) begin
        win_vld = 1'b1;
        win_idx = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign ptr_nxt = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  assign sum     = {1'b0, lat_a} + {1'b0, lat_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      lat_a      <= '0;
      lat_b      <= '0;
      bus.gnt    <= '0;
      bus.result <= '0;
      bus.ovf    <= 1'b0;
      bus.done   <= 1'b0;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          if (win_vld) begin
            bus.gnt  <= NREQ'(1) << win_idx;
            lat_a    <= bus.op_a[win_idx*WIDTH +: WIDTH];
            lat_b    <= bus.op_b[win_idx*WIDTH +: WIDTH];
            ptr      <= ptr_nxt;
            bus.busy <= 1'b1;
            state    <= EXEC;
          end
        end
        EXEC: begin
`ifdef OVERFLOW_SAT_EN
          bus.result <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
          bus.result <= sum[WIDTH-1:0];
`endif
          bus.ovf  <= sum[WIDTH];
          bus.done <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed bench for shared_adder_arbiter at WIDTH=4, NREQ=4; expected values are hand-computed.
module tb_shared_adder_arbiter;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  shared_adder_arbiter_if #(.WIDTH(4), .NREQ(4)) bus ();

  shared_adder_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.op_a[i*4 +: 4] = a;
    bus.op_b[i*4 +: 4] = b;
  endtask

  logic [3:0] rr_gnt [5];
  logic [3:0] rr_sum [5];

  initial begin
    n_err   = 0;
    n_chk   = 0;
    rst     = 1'b1;
    bus.req  = '0;
    bus.op_a = '0;
    bus.op_b = '0;
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_sum = '{4'd3, 4'd8, 4'd10, 4'd15, 4'd3};

    tick();
    tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    rst = 1'b0;
    tick();
    check("idle_gnt", bus.gnt, 0);
    check("idle_busy", bus.busy, 0);

    // Single request, operands disturbed after latching.
    set_ops(0, 4'd3, 4'd4);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_busy", bus.busy, 1);
    check("t1_done_early", bus.done, 0);
    bus.req = 4'b0000;
    set_ops(0, 4'd15, 4'd15);
    tick();
    check("t1_result", bus.result, 7);
    check("t1_ovf", bus.ovf, 0);
    check("t1_done", bus.done, 1);
    tick();
    check("t1_gnt_clr", bus.gnt, 0);
    check("t1_done_clr", bus.done, 0);
    check("t1_busy_clr", bus.busy, 0);
    check("t1_result_hold", bus.result, 7);

    // Overflow from requester 1 (ptr now 1).
    set_ops(1, 4'd9, 4'd8);
    bus.req = 4'b0010;
    tick();
    check("t2_gnt", bus.gnt, 4'b0010);
    bus.req = 4'b0000;
    tick();
`ifdef OVERFLOW_SAT_EN
    check("t2_result", bus.result, 15);
`else
    check("t2_result", bus.result, 1);
`endif
    check("t2_ovf", bus.ovf, 1);
    check("t2_done", bus.done, 1);
    tick();
    check("t2_busy_clr", bus.busy, 0);

    // Start an op at ptr=2, then reset asynchronously while DONE.
    set_ops(0, 4'd1, 4'd2);
    set_ops(1, 4'd2, 4'd6);
    set_ops(2, 4'd5, 4'd5);
    set_ops(3, 4'd8, 4'd7);
    bus.req = 4'b1111;
    tick();
    check("t3_gnt_pre", bus.gnt, 4'b0100);
    tick();
    check("t3_done_pre", bus.done, 1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", bus.gnt, 0);
    check("arst_result", bus.result, 0);
    check("arst_ovf", bus.ovf, 0);
    check("arst_done", bus.done, 0);
    check("arst_busy", bus.busy, 0);
    tick();
    rst = 1'b0;

    // Held 1111: rotation from ptr=0, each grant spans EXEC+DONE, 3-cycle period.
    for (int g = 0; g < 5; g++) begin
      tick();
      check("rr_gnt_exec", bus.gnt, rr_gnt[g]);
      check("rr_done_exec", bus.done, 0);
      tick();
      check("rr_gnt_done", bus.gnt, rr_gnt[g]);
      check("rr_done", bus.done, 1);
      check("rr_result", bus.result, rr_sum[g]);
      tick();
      check("rr_gnt_idle", bus.gnt, 0);
      check("rr_busy_idle", bus.busy, 0);
    end
    bus.req = 4'b0000;

    // Request dropped during EXEC still completes (ptr now 1).
    set_ops(2, 4'd6, 4'd7);
    bus.req = 4'b0100;
    tick();
    check("t4_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    set_ops(2, 4'd0, 4'd0);
    tick();
    check("t4_done", bus.done, 1);
    check("t4_result", bus.result, 13);
    check("t4_ovf", bus.ovf, 0);
    tick();
    check("t4_busy_clr", bus.busy, 0);
    tick();
    check("t4_gnt_idle", bus.gnt, 0);

    // Reset during EXEC of requester 2, then 0101 restarts from ptr=0.
    set_ops(0, 4'd2, 4'd3);
    bus.req = 4'b0100;
    tick();
    check("t5_gnt", bus.gnt, 4'b0100);
    #2;
    rst = 1'b1;
    #1;
    check("t5_arst_busy", bus.busy, 0);
    check("t5_arst_done", bus.done, 0);
    tick();
    check("t5_no_done", bus.done, 0);
    rst = 1'b0;
    bus.req = 4'b0101;
    tick();
    check("t5_gnt_after", bus.gnt, 4'b0001);
    check("t5_done_after", bus.done, 0);
    tick();
    check("t5_done", bus.done, 1);
    check("t5_result", bus.result, 5);
    tick();
    tick();
    check("t5_next_gnt", bus.gnt, 4'b0100);
    bus.req = 4'b0000;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
